// File: rtl/tick_monitor.sv
// ---------------------------------------------------------------------------
// tick_monitor : measures tick-to-tick period, tracks lock, flags bad ticks
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tick_monitor #(
  parameter int EXPECTED   = 100,
  parameter int TOLERANCE  = 0,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 2*EXPECTED,
  localparam int W         = $clog2(TIMEOUT+1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_in,
  output logic [W-1:0] period,
  output logic         period_valid,
  output logic         locked,
  output logic         err_early,
  output logic         err_late,
  output logic [7:0]   err_cnt
);

  localparam int GW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;

  localparam logic [W-1:0]  LO_BOUND   = W'(EXPECTED - TOLERANCE);
  localparam logic [W-1:0]  HI_BOUND   = W'(EXPECTED + TOLERANCE);
  localparam logic [W-1:0]  TIMEOUT_W  = W'(TIMEOUT);
  localparam logic [GW-1:0] GOOD_LAST  = GW'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [GW-1:0] good_q, good_d;
  logic [W-1:0]  period_q, period_d;
  logic          period_valid_q, period_valid_d;
  logic          locked_q, locked_d;
  logic          err_early_q, err_early_d;
  logic          err_late_q, err_late_d;
  logic [7:0]    err_cnt_q, err_cnt_d;

  logic [W-1:0]  meas;
  logic          in_tol;
  logic          is_early;
  logic          timeout_hit;
  logic [7:0]    err_cnt_inc;

  // meas is the period that would be reported if a tick is sampled this edge
  assign meas        = cnt_q + W'(1);
  assign is_early    = (meas < LO_BOUND);
  assign in_tol      = (meas >= LO_BOUND) && (meas <= HI_BOUND);
  assign timeout_hit = (meas == TIMEOUT_W);
  assign err_cnt_inc = (err_cnt_q == 8'hFF) ? 8'hFF : (err_cnt_q + 8'd1);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    good_d         = good_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    locked_d       = locked_q;
    err_early_d    = 1'b0;
    err_late_d     = 1'b0;
    err_cnt_d      = err_cnt_q;

    case (state_q)
      IDLE: begin
        cnt_d    = '0;
        good_d   = '0;
        locked_d = 1'b0;
        if (en_in) begin
          state_d = SYNC;
        end
      end

      SYNC: begin
        if (en_in) begin
          cnt_d          = '0;
          period_d       = meas;
          period_valid_d = 1'b1;
          if (in_tol) begin
            if (good_q == GOOD_LAST) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
              good_d   = '0;
            end else begin
              good_d = good_q + GW'(1);
            end
          end else begin
            good_d = '0;
          end
        end else if (timeout_hit) begin
          state_d = IDLE;
          cnt_d   = '0;
          good_d  = '0;
        end else begin
          cnt_d = meas;
        end
      end

      LOCKED: begin
        if (en_in) begin
          cnt_d          = '0;
          period_d       = meas;
          period_valid_d = 1'b1;
          if (!in_tol) begin
            err_early_d = is_early;
            err_late_d  = !is_early;
            err_cnt_d   = err_cnt_inc;
            locked_d    = 1'b0;
            good_d      = '0;
            state_d     = SYNC;
          end
        end else if (timeout_hit) begin
          // Missing tick: reported as late, then resynchronise from scratch
          err_late_d = 1'b1;
          err_cnt_d  = err_cnt_inc;
          locked_d   = 1'b0;
          good_d     = '0;
          cnt_d      = '0;
          state_d    = IDLE;
        end else begin
          cnt_d = meas;
        end
      end

      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        good_d   = '0;
        locked_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      good_q         <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      err_early_q    <= 1'b0;
      err_late_q     <= 1'b0;
      err_cnt_q      <= 8'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      good_q         <= good_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      err_early_q    <= err_early_d;
      err_late_q     <= err_late_d;
      err_cnt_q      <= err_cnt_d;
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign err_early    = err_early_q;
  assign err_late     = err_late_q;
  assign err_cnt      = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_tick_monitor.sv
// ---------------------------------------------------------------------------
// tb_tick_monitor : directed self-checking bench for tick_monitor
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_tick_monitor;

  localparam int W0 = $clog2(200+1);
  localparam int W2 = $clog2(8+1);

  logic clk;
  logic rst_n;
  logic en_in;

  logic [W0-1:0] period0, period1;
  logic [W2-1:0] period2;
  logic pv0, pv1, pv2;
  logic lk0, lk1, lk2;
  logic ee0, ee1, ee2;
  logic el0, el1, el2;
  logic [7:0] ec0, ec1, ec2;

  int tests  = 0;
  int failed = 0;
  int sel    = 0;

  logic [31:0] obs_period;
  logic        obs_pv, obs_lk, obs_ee, obs_el;
  logic [7:0]  obs_ec;

  // Defaults: EXPECTED=100, TOLERANCE=0, LOCK_COUNT=4, TIMEOUT=200
  tick_monitor u_def (
    .clk(clk), .rst_n(rst_n), .en_in(en_in),
    .period(period0), .period_valid(pv0), .locked(lk0),
    .err_early(ee0), .err_late(el0), .err_cnt(ec0)
  );

  tick_monitor #(.TOLERANCE(2)) u_tol (
    .clk(clk), .rst_n(rst_n), .en_in(en_in),
    .period(period1), .period_valid(pv1), .locked(lk1),
    .err_early(ee1), .err_late(el1), .err_cnt(ec1)
  );

  // Short period with single-period lock so saturation is reachable quickly
  tick_monitor #(.EXPECTED(4), .TOLERANCE(0), .LOCK_COUNT(1), .TIMEOUT(8)) u_sat (
    .clk(clk), .rst_n(rst_n), .en_in(en_in),
    .period(period2), .period_valid(pv2), .locked(lk2),
    .err_early(ee2), .err_late(el2), .err_cnt(ec2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    obs_period = 32'd0;
    obs_pv     = 1'b0;
    obs_lk     = 1'b0;
    obs_ee     = 1'b0;
    obs_el     = 1'b0;
    obs_ec     = 8'd0;
    case (sel)
      0: begin
        obs_period = 32'(period0); obs_pv = pv0; obs_lk = lk0;
        obs_ee = ee0; obs_el = el0; obs_ec = ec0;
      end
      1: begin
        obs_period = 32'(period1); obs_pv = pv1; obs_lk = lk1;
        obs_ee = ee1; obs_el = el1; obs_ec = ec1;
      end
      default: begin
        obs_period = 32'(period2); obs_pv = pv2; obs_lk = lk2;
        obs_ee = ee2; obs_el = el2; obs_ec = ec2;
      end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // n idle cycles on the selected instance; no pulse may appear meanwhile
  task automatic wait_quiet(input string tag, input int n);
    logic stray;
    stray = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (obs_pv || obs_ee || obs_el) stray = 1'b1;
    end
    if (n > 0) check({tag, "_quiet"}, 32'(stray), 32'd0);
  endtask

  // Tick sampled exactly gap edges after the previous one; returns after its edge
  task automatic send_tick(input string tag, input int gap);
    wait_quiet(tag, gap - 1);
    en_in = 1'b1;
    @(negedge clk);
    en_in = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int pv, input int per,
                            input int ee, input int el, input int lk, input int ec);
    check({tag, "_pv"},     32'(obs_pv), 32'(pv));
    if (pv != 0) check({tag, "_period"}, obs_period, 32'(per));
    check({tag, "_early"},  32'(obs_ee), 32'(ee));
    check({tag, "_late"},   32'(obs_el), 32'(el));
    check({tag, "_locked"}, 32'(obs_lk), 32'(lk));
    check({tag, "_errcnt"}, 32'(obs_ec), 32'(ec));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    en_in = 1'b0;
    sel   = 0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check("rst_period", obs_period, 32'd0);
      expect_out("rst", 0, 0, 0, 0, 0, 0);
    end
    sel = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Nominal ticks: first tick in IDLE is silent, lock on the 5th tick
    send_tick("t1_first", 5);
    expect_out("t1_first", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      send_tick("t1_sync", 100);
      expect_out("t1_sync", 1, 100, 0, 0, 0, 0);
    end
    send_tick("t1_lock", 100);
    expect_out("t1_lock", 1, 100, 0, 0, 1, 0);

    // Early tick while locked, then relock after 4 good periods
    send_tick("t2_early", 97);
    expect_out("t2_early", 1, 97, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      send_tick("t2_resync", 100);
      expect_out("t2_resync", 1, 100, 0, 0, 0, 1);
    end
    send_tick("t2_relock", 100);
    expect_out("t2_relock", 1, 100, 0, 0, 1, 1);

    // Missing tick: timeout 200 cycles after the last tick
    wait_quiet("t3_wait", 199);
    check("t3_pre_late", 32'(obs_el), 32'd0);
    @(negedge clk);
    expect_out("t3_timeout", 0, 0, 0, 1, 0, 2);
    send_tick("t3_idle_tick", 10);
    expect_out("t3_idle_tick", 0, 0, 0, 0, 0, 2);
    send_tick("t3_next", 100);
    expect_out("t3_next", 1, 100, 0, 0, 0, 2);

    // Tolerance window of +/-2
    do_reset();
    sel = 1;
    send_tick("t4_first", 5);
    expect_out("t4_first", 0, 0, 0, 0, 0, 0);
    send_tick("t4_98", 98);
    expect_out("t4_98", 1, 98, 0, 0, 0, 0);
    send_tick("t4_102", 102);
    expect_out("t4_102", 1, 102, 0, 0, 0, 0);
    send_tick("t4_101", 101);
    expect_out("t4_101", 1, 101, 0, 0, 0, 0);
    send_tick("t4_99", 99);
    expect_out("t4_99", 1, 99, 0, 0, 1, 0);
    send_tick("t4_103", 103);
    expect_out("t4_103", 1, 103, 0, 1, 0, 1);

    // en_in stuck high: period 1 every cycle, never locks, no errors
    do_reset();
    sel = 0;
    en_in = 1'b1;
    @(negedge clk);
    expect_out("t5_first", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      expect_out("t5_stuck", 1, 1, 0, 0, 0, 0);
    end
    en_in = 1'b0;

    // Error counter saturation, then asynchronous reset mid-lock
    do_reset();
    sel = 2;
    send_tick("t6_first", 2);
    expect_out("t6_first", 0, 0, 0, 0, 0, 0);
    send_tick("t6_lock", 4);
    expect_out("t6_lock", 1, 4, 0, 0, 1, 0);
    for (int i = 0; i < 300; i++) begin
      send_tick("t6_early", 3);
      expect_out("t6_early", 1, 3, 1, 0, 0, (i + 1 > 255) ? 255 : i + 1);
      send_tick("t6_relock", 4);
      check("t6_relock_locked", 32'(obs_lk), 32'd1);
    end
    expect_out("t6_sat", 1, 4, 0, 0, 1, 255);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_arst_period", obs_period, 32'd0);
    expect_out("t6_arst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
